// File: rtl/insn_encoder.sv
// Instruction encoder: packs fields into 16-bit words and range-checks immediates, feeding an output FIFO.
// Define ENCODE_SATURATE_EN to clamp out-of-range immediates instead of dropping them.
module insn_encoder #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_opcode,
    input  logic [1:0]  in_op,
    input  logic [2:0]  in_rn,
    input  logic [2:0]  in_rd,
    input  logic [1:0]  in_sh,
    input  logic [2:0]  in_rm,
    input  logic [1:0]  in_fmt,
    input  logic [15:0] in_value,
    output logic [15:0] out_insn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    function automatic logic fits_imm8(input logic signed [15:0] v);
        return v[15:7] == {9{v[7]}};
    endfunction

    function automatic logic fits_imm5(input logic signed [15:0] v);
        return v[15:4] == {12{v[4]}};
    endfunction

    function automatic logic [7:0] sat_imm8(input logic signed [15:0] v);
        if (fits_imm8(v)) return v[7:0];
        return v[15] ? 8'h80 : 8'h7F;
    endfunction

    function automatic logic [4:0] sat_imm5(input logic signed [15:0] v);
        if (fits_imm5(v)) return v[4:0];
        return v[15] ? 5'h10 : 5'h0F;
    endfunction

    logic signed [15:0] value_s;
    logic [15:0]        enc_insn;
    logic               range_ok;
    logic               fmt_rsvd;
    logic               accept;
    logic               bad;
    logic               keep;
    logic               push;
    logic               pop;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic [7:0]         err_count_q, err_count_d;
    logic [15:0]        mem_q [FIFO_DEPTH];
    logic [15:0]        mem_d [FIFO_DEPTH];

    assign value_s = in_value;

    always_comb begin
        enc_insn = {in_opcode, in_op, in_rn, 8'h00};
        range_ok = 1'b1;
        fmt_rsvd = 1'b0;
        case (in_fmt)
            2'd0: enc_insn[7:0] = {in_rd, in_sh, in_rm};
            2'd1: begin
                range_ok      = fits_imm8(value_s);
                enc_insn[7:0] = sat_imm8(value_s);
            end
            2'd2: begin
                range_ok      = fits_imm5(value_s);
                enc_insn[7:0] = {in_rd, sat_imm5(value_s)};
            end
            default: fmt_rsvd = 1'b1;
        endcase
    end

    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign out_insn  = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
    assign err       = err_q;
    assign err_count = err_count_q;

    assign accept = in_valid && in_ready;
    assign bad    = fmt_rsvd || !range_ok;
`ifdef ENCODE_SATURATE_EN
    assign keep   = !fmt_rsvd;
`else
    assign keep   = !bad;
`endif
    // Rejected requests still complete the handshake; they just never occupy a slot.
    assign push   = accept && keep;
    assign pop    = out_valid && out_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_d       = accept && bad;
        err_count_d = err_count_q;
        mem_d       = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = enc_insn;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (accept && bad && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    // Storage needs no reset: out_insn is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: doc/insn_encoder.md
INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, output FIFO entries (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request carries valid fields.
REQ-005 SHALL have port in_ready  output  1  encoder accepts a request this cycle.
REQ-006 SHALL have ports in_opcode input 3, in_op input 2, in_rn input 3, in_rd input 3, in_sh input 2, in_rm input 3: instruction fields.
REQ-007 SHALL have port in_fmt  input  2  format: 0 register, 1 imm8, 2 imm5, 3 reserved.
REQ-008 SHALL have port in_value  input  16  signed immediate to be narrowed.
REQ-009 SHALL have port out_insn  output  16  encoded instruction at FIFO head.
REQ-010 SHALL have port out_valid  output  1  out_insn is valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes out_insn.
REQ-012 SHALL have port err  output  1  registered one-cycle pulse per rejected or clamped request.
REQ-013 SHALL have port err_count  output  8  saturating count of err pulses.

Function
REQ-014 SHALL transfer a request when in_valid && in_ready at a clock edge; in_ready = (FIFO count < FIFO_DEPTH), with no combinational path from out_ready.
REQ-015 SHALL pack bits [15:13] opcode, [12:11] op, [10:8] rn for every format.
REQ-016 fmt 0 SHALL pack [7:5] rd, [4:3] sh, [2:0] rm; in_value ignored.
REQ-017 fmt 1 SHALL pack [7:0] in_value[7:0]; rd/sh/rm ignored; fits iff in_value[15:7] are all equal.
REQ-018 fmt 2 SHALL pack [7:5] rd, [4:0] in_value[4:0]; sh/rm ignored; fits iff in_value[15:4] are all equal.
REQ-019 Out-of-range immediate or fmt 3 SHALL assert err in the cycle after acceptance and increment err_count, holding at 255.
REQ-020 A transfer into an empty FIFO SHALL appear on out_insn with out_valid = 1 the next cycle (latency 1).
REQ-021 SHALL pop the FIFO head when out_valid && out_ready; out_insn/out_valid stable while out_valid && !out_ready.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; a full FIFO SHALL accept a new push only on the cycle after a pop.
REQ-023 SHALL preserve strict FIFO order; pointers wrap modulo FIFO_DEPTH.
REQ-024 Dropped requests SHALL consume no FIFO slot but still complete the handshake.

Reset
REQ-025 reset SHALL asynchronously clear FIFO count and pointers, out_valid = 0, out_insn = 0, err = 0, err_count = 0.
REQ-026 in_ready SHALL be 1 during and immediately after reset; entries in flight at reset SHALL be discarded.

Configuration
REQ-027 Macro ENCODE_SATURATE_EN SHALL select range-error handling.
REQ-028 Without ENCODE_SATURATE_EN, an out-of-range immediate SHALL be dropped (not pushed).
REQ-029 With ENCODE_SATURATE_EN, the immediate SHALL be clamped (imm8 to 0x7F/0x80, imm5 to 0x0F/0x10) and pushed; err/err_count still update; fmt 3 is always dropped.

Verification
REQ-030 fmt 1, opcode 110, op 10, rn 3, value 16'hFFED -> out_insn 16'hD3ED one cycle later, err 0.
REQ-031 fmt 2, opcode 011, op 00, rn 1, rd 2, value 16'hFFF3 -> 16'h6153; fmt 0, opcode 101, op 00, rn 1, rd 2, sh 01, rm 3 -> 16'hA14B.
REQ-032 fmt 1, rn 3, value 16'h0080 -> without macro: no output, err pulse, err_count 1; with macro: 16'hD37F, err pulse, err_count 1.
REQ-033 out_ready 0, three back-to-back requests -> in_ready drops after 2; release out_ready -> all 3 emerge in order, count never exceeds 2.
REQ-034 300 fmt 3 requests -> err_count saturates at 255, no output; assert reset mid-stream -> out_valid 0, err_count 0 immediately.
